reg_bank: RTL
=============

// Module: reg_bank
//
// PURPOSE
//   Multi-word register bank for the sequential processor. It consumes the
//   stored-bit behaviour of the d_flipflop stage, scaled to DEPTH words of
//   WIDTH bits. It has one write port and two registered read ports feeding
//   the ALU operand path.
//   A bulk-clear sequencer zeroes the bank one word per cycle on request.
//
// PARAMETERS
//   WIDTH  8  data bits per word
//   DEPTH  8  number of words; must be a power of 2, >= 2
//   AW     3  address bits; must equal log2(DEPTH)
//
// PORTS
//   clk      in   1      rising-edge clock, single domain
//   rst      in   1      synchronous, active-high reset
//   we       in   1      write enable
//   waddr    in   AW     write address
//   wdata    in   WIDTH  write data
//   raddr_a  in   AW     read port A address
//   rdata_a  out  WIDTH  read port A data, registered
//   raddr_b  in   AW     read port B address
//   rdata_b  out  WIDTH  read port B data, registered
//   clr_req  in   1      bulk-clear request; sampled only in IDLE
//   busy     out  1      high while the clear sequence runs
//   wr_drop  out  1      1-cycle pulse: a write was rejected during a clear
//
// BEHAVIOUR
//   - Reset: rst=1 at a clk edge overrides all other inputs. On that edge:
//     all words <= 0, rdata_a/rdata_b <= 0, busy <= 0, wr_drop <= 0,
//     FSM <= IDLE, clear pointer <= 0. A reset mid-clear aborts the clear.
//   - Write in IDLE: if we=1, mem[waddr] <= wdata at the edge.
//   - Reads: rdata_x <= mem[raddr_x] at every edge, in both states.
//     Latency is 1 cycle; the ports are independent and may use the same
//     address.
//   - Read/write collision: raddr_x == write target in the same cycle.
//     The result is set by the optional feature (see CONFIGURATION).
//   - FSM IDLE:
//     - clr_req=1 -> CLEAR, with ptr <= 0 and busy <= 1.
//     - A write in that same cycle is performed; the clear wipes it later.
//   - FSM CLEAR:
//     - Each cycle: mem[ptr] <= 0 and ptr <= ptr+1.
//     - At ptr == DEPTH-1: write 0, then go to IDLE, busy <= 0, ptr <= 0.
//     - busy is high for exactly DEPTH cycles.
//     - clr_req is ignored.
//     - we=1 -> write discarded and wr_drop <= 1 for the next cycle;
//       otherwise wr_drop <= 0.
//   - wr_drop is 0 in IDLE, except on the cycle after the last CLEAR-cycle
//     drop.
//   - The pointer wraps modulo DEPTH. No arithmetic on data.
//
// CONFIGURATION
//   REG_BANK_FORWARD_EN
//     Defined: a read of the word being written in the same cycle returns
//     the new value.
//       - In IDLE, that value is wdata.
//       - In CLEAR, a read of mem[ptr] returns 0.
//     Undefined: such a read returns the pre-write contents. The new value
//     is visible one cycle later.
//
// TESTING
//   1. rst=1 for 2 cycles, then release
//      -> rdata_a = rdata_b = 0, busy = 0, wr_drop = 0;
//         every address reads 0.
//   2. Write 0xA5 @3, then 0x3C @5; read A=3, B=5 on the next cycle
//      -> one cycle later rdata_a = 0xA5, rdata_b = 0x3C.
//   3. Write 0x77 @2 with raddr_a=2 in the same cycle
//      -> next-cycle rdata_a = 0x77 with REG_BANK_FORWARD_EN,
//         old value 0x00 without it; 0x77 on the following cycle either way.
//   4. Fill all words with 0xFF; pulse clr_req
//      -> busy high for exactly 8 cycles; all words read 0 afterwards.
//   5. During a clear, we=1 @6 with 0x11
//      -> wr_drop = 1 for 1 cycle; mem[6] = 0 after the clear.
//   6. Assert rst at clear cycle 3
//      -> busy = 0 the next cycle, FSM IDLE; a new clr_req restarts at ptr 0.

Source files
------------

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - DEPTH x WIDTH register bank, 1 write / 2 registered reads, bulk clear
// Optional same-cycle read forwarding: define REG_BANK_FORWARD_EN.
module reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_val;

    // A clear cycle is just a write of zero to mem[ptr]; host writes only land in IDLE.
    assign wr_en   = (state == CLEAR) || we;
    assign wr_addr = (state == CLEAR) ? ptr : waddr;
    assign wr_val  = (state == CLEAR) ? '0 : wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (ptr == LAST_ADDR) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            wr_drop <= 1'b0;
        end else begin
            ptr     <= (state == CLEAR) ? ptr + AW'(1) : '0;
            wr_drop <= (state == CLEAR) && we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
`ifdef REG_BANK_FORWARD_EN
            rdata_a <= (wr_en && raddr_a == wr_addr) ? wr_val : mem[raddr_a];
            rdata_b <= (wr_en && raddr_b == wr_addr) ? wr_val : mem[raddr_b];
`else
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
`endif
        end
    end

endmodule
